// File: rtl/a2d_pkg.sv
// Shared types and constants for the SPI A2D responder.
//   FRAME_LEN  : bits per SPI command/response frame
//   RES_W      : sample (conversion) width
//   CHNL_W     : channel index width; field sits at [CHNL_MSB:CHNL_LSB] of a command
package a2d_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned RES_W     = 12;
  localparam int unsigned CHNL_W    = 3;
  localparam int unsigned NUM_CHNL  = 8;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned CHNL_MSB  = 13;
  localparam int unsigned CHNL_LSB  = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Extract the channel field from a received command frame.
  function automatic logic [CHNL_W-1:0] cmd_chnl(input logic [FRAME_LEN-1:0] c);
    return c[CHNL_MSB:CHNL_LSB];
  endfunction

endpackage

// File: rtl/a2d_sync.sv
// Two-flop synchronizer plus history flop with edge detection.
//   clk, rst_n : system clock, async active-low reset
//   i_async    : asynchronous input
//   o_rise_c   : one-cycle high when the synchronized input rises
//   o_fall_c   : one-cycle high when the synchronized input falls
module a2d_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Synchronizer chain; reset to the idle level of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_hist <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_rise_c = r_sync & ~r_hist;
  assign o_fall_c = ~r_sync & r_hist;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI slave emulating an A2D: holds 8 sample registers written from the
// system side, receives 16-bit command frames and returns the sample of the
// channel named in the previous valid frame.
//   clk, rst_n          : system clock, async active-low reset
//   a2d_SS_n, SCLK, MOSI: SPI inputs (asynchronous)
//   MISO                : SPI data out, MSB first
//   wr_en/wr_chnl/wr_data: sample register load port
//   cmd                 : last valid command frame
//   frm_cmplt, frm_err  : one-cycle end-of-frame status pulses
module a2d_spi_resp
  import a2d_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a2d_SS_n,
  input  logic                 SCLK,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic                 wr_en,
  input  logic [CHNL_W-1:0]    wr_chnl,
  input  logic [RES_W-1:0]     wr_data,
  output logic [FRAME_LEN-1:0] cmd,
  output logic                 frm_cmplt,
  output logic                 frm_err
);

  logic w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall;

  a2d_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_async  (a2d_SS_n),
    .o_rise_c (w_ss_rise),
    .o_fall_c (w_ss_fall)
  );

  a2d_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_async  (SCLK),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall)
  );

  // MOSI needs only the level, aligned with the SCLK sync stage.
  logic r_mosi_meta, r_mosi_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // Sample registers, loaded from the system side.
  logic [RES_W-1:0] r_sample [NUM_CHNL];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CHNL); i++) r_sample[i] <= '0;
    end else if (wr_en) begin
      r_sample[wr_chnl] <= wr_data;
    end
  end

  state_e               r_state, w_state_nxt;
  logic [FRAME_LEN-1:0] r_tx, w_tx_nxt;
  logic [FRAME_LEN-1:0] r_rx, w_rx_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [FRAME_LEN-1:0] r_cmd, w_cmd_nxt;
  logic [CHNL_W-1:0]    r_chnl, w_chnl_nxt;
  logic                 r_frm_cmplt, w_frm_cmplt_nxt;
  logic                 r_frm_err, w_frm_err_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath update. tx is cleared on leaving SHIFT so MISO
  // can be driven straight from its MSB and reads 0 while idle.
  always_comb begin
    w_state_nxt     = r_state;
    w_tx_nxt        = r_tx;
    w_rx_nxt        = r_rx;
    w_cnt_nxt       = r_cnt;
    w_cmd_nxt       = r_cmd;
    w_chnl_nxt      = r_chnl;
    w_frm_cmplt_nxt = 1'b0;
    w_frm_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        // SCLK edges in IDLE (including one coincident with SS_n fall) are ignored.
        if (w_ss_fall) begin
          w_state_nxt = SHIFT;
          w_tx_nxt    = {{(FRAME_LEN-RES_W){1'b0}}, r_sample[r_chnl]};
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = '0;
          if (r_cnt == CNT_W'(FRAME_LEN)) begin
            w_cmd_nxt       = r_rx;
            w_chnl_nxt      = cmd_chnl(r_rx);
            w_frm_cmplt_nxt = 1'b1;
          end else begin
            w_frm_err_nxt = 1'b1;
          end
        end else begin
          if (w_sclk_rise) begin
            w_rx_nxt = {r_rx[FRAME_LEN-2:0], r_mosi_sync};
            if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          // A non-zero count means a rise has been seen this frame.
          if (w_sclk_fall && (r_cnt != '0)) begin
            w_tx_nxt = {r_tx[FRAME_LEN-2:0], 1'b0};
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx        <= '0;
      r_rx        <= '0;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_chnl      <= '0;
      r_frm_cmplt <= 1'b0;
      r_frm_err   <= 1'b0;
    end else begin
      r_tx        <= w_tx_nxt;
      r_rx        <= w_rx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd       <= w_cmd_nxt;
      r_chnl      <= w_chnl_nxt;
      r_frm_cmplt <= w_frm_cmplt_nxt;
      r_frm_err   <= w_frm_err_nxt;
    end
  end

  assign MISO      = r_tx[FRAME_LEN-1];
  assign cmd       = r_cmd;
  assign frm_cmplt = r_frm_cmplt;
  assign frm_err   = r_frm_err;

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with all flops clocked on posedge clk and reset on negedge rst_n.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a2d_SS_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-005 SCLK  input  1  SPI serial clock (idle low), asynchronous to clk.
REQ-006 MOSI  input  1  command data from the master, MSB first.
REQ-007 MISO  output  1  conversion data to the master, MSB first.
REQ-008 wr_en  input  1  loads one sample register for one cycle.
REQ-009 wr_chnl  input  3  index of the sample register to load.
REQ-010 wr_data  input  12  value loaded into sample register wr_chnl.
REQ-011 cmd  output  16  last complete command frame received.
REQ-012 frm_cmplt  output  1  one-cycle pulse when a valid 16-bit frame ends.
REQ-013 frm_err  output  1  one-cycle pulse when a frame ends with a bit count other than 16.

Function
REQ-014 The block SHALL pass a2d_SS_n, SCLK and MOSI through two synchronizer flops plus one history flop.
- Edges are detected on the synchronized signals.
- Master SCLK half-period SHALL be at least 4 clk periods.
REQ-015 The block SHALL hold 8 sample registers, each 12 bits wide.
- On wr_en, sample[wr_chnl] <= wr_data in the next cycle.
- A write to the channel currently being shifted out does not alter the frame in progress.
REQ-016 The FSM SHALL have states IDLE and SHIFT.
- IDLE->SHIFT on a detected SS_n fall.
- SHIFT->IDLE on a detected SS_n rise.
REQ-017 On IDLE->SHIFT, the tx shift register SHALL load {4'b0000, sample[cur_chnl]}, where cur_chnl is the latched channel.
- MISO shows tx[15] before the first SCLK rise.
REQ-018 In SHIFT, on each detected SCLK rise, the block SHALL:
- shift the synchronized MOSI into the LSB of the rx shift register;
- increment a 5-bit bit counter, saturating at 31.
REQ-019 In SHIFT, on each detected SCLK fall, the tx register SHALL shift left by one, filling with 0.
- A fall that occurs before the first rise is ignored.
REQ-020 MISO SHALL equal tx[15] in SHIFT and 1'b0 in IDLE.
REQ-021 On SS_n rise with bit count == 16, in the same cycle the block SHALL:
- set cmd <= rx;
- set cur_chnl <= rx[13:11];
- pulse frm_cmplt.
REQ-022 On SS_n rise with bit count != 16, the block SHALL pulse frm_err and leave cmd and cur_chnl unchanged.
REQ-023 Each frame returns the conversion for the channel commanded in the previous valid frame (pipelined by one frame).
REQ-024 SCLK edges seen while in IDLE SHALL be ignored.
REQ-025 An SS_n fall and an SCLK edge detected in the same cycle SHALL be handled as the SS_n fall only.
REQ-026 The bit counter SHALL clear on every IDLE->SHIFT transition.

Reset
REQ-027 On rst_n low, the block SHALL set:
- state = IDLE;
- MISO = 0, cmd = 16'h0000, frm_cmplt = 0, frm_err = 0;
- cur_chnl = 0, all sample registers = 12'h000;
- synchronizer flops = {SS_n:1, SCLK:0, MOSI:0}.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no frm_cmplt or frm_err pulse.
- After release, the FSM waits for a fresh SS_n fall.

Structure
REQ-029 Package a2d_pkg SHALL hold:
- the state enum {IDLE, SHIFT};
- FRAME_LEN = 16, RES_W = 12, CHNL_W = 3;
- the channel field position [13:11].
REQ-030 A single sub-module, a2d_sync, SHALL provide the two-flop synchronizer with rise/fall edge outputs.
- It is instantiated once each for SS_n and SCLK.
- MOSI uses the synchronizer only.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, write sample[5]=12'hA5C, then frame cmd 16'h2800 (chnl 5) -> MISO returns 16'h0000, cmd=16'h2800, frm_cmplt pulses once.
- Follow-up frame cmd 16'h0000 -> MISO returns 16'h0A5C; cur_chnl becomes 0.
- Frame of only 12 SCLK cycles -> frm_err pulses once; cmd and cur_chnl unchanged; next valid frame returns the prior channel's value.
- Frame of 18 SCLK cycles -> frm_err pulses, no frm_cmplt.
- wr_en to sample[5]=12'h123 mid-frame while shifting chnl 5 -> current frame still returns 16'h0A5C, next frame returns 16'h0123.
- rst_n pulsed low after 8 SCLK cycles -> no pulse, MISO=0, cmd=16'h0000, next full frame is accepted normally.
